dmi_responder: RTL and testbench

DMI_RESPONDER -- requirements
Module: dmi_responder

---
 rtl/dmi_responder.sv | 202 ++++++++++++++++++++
 tb/tb_dmi_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dmi_responder.sv
// dmi_responder
//
// Debug-module-interface register responder. It accepts one DMI request at a
// time, services it against a bank of 32-bit registers and returns a single
// response through a valid/ready handshake.
//
// Parameters
//   NUM_REGS   : number of 32-bit registers in the bank (1..32)
//   ADDR_BASE  : DMI address of register 0
//   RD_LATENCY : extra wait cycles inserted before a read response (0..15)
//
// Ports
//   clk                  : sole clock, all state on the rising edge
//   reset_n              : asynchronous active-low reset
//   debug_req_valid      : request present
//   debug_req_ready      : responder accepts request (only while idle)
//   debug_req_bits_addr  : 7-bit register address
//   debug_req_bits_op    : 0 nop, 1 read, 2 write, 3 reserved
//   debug_req_bits_data  : write data
//   debug_resp_valid     : response present
//   debug_resp_ready     : initiator accepts response
//   debug_resp_bits_resp : 0 success, 2 failed
//   debug_resp_bits_data : read data, otherwise 0
//   regs_q               : flat bank contents, register i at [32i+31:32i]
//
// Configuration macro
//   DMI_RESPONDER_ADDR_CHECK_EN : when defined, reads/writes outside the bank
//   answer "failed"; otherwise they answer success with zero data and writes
//   are silently dropped.

module dmi_responder #(
    parameter int unsigned NUM_REGS   = 16,
    parameter logic [6:0]  ADDR_BASE  = 7'h04,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     debug_req_valid,
    output logic                     debug_req_ready,
    input  logic [6:0]               debug_req_bits_addr,
    input  logic [1:0]               debug_req_bits_op,
    input  logic [31:0]              debug_req_bits_data,
    output logic                     debug_resp_valid,
    input  logic                     debug_resp_ready,
    output logic [1:0]               debug_resp_bits_resp,
    output logic [31:0]              debug_resp_bits_data,
    output logic [32*NUM_REGS-1:0]   regs_q
);

    localparam int unsigned IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned ADDR_END = 32'(ADDR_BASE) + NUM_REGS;
    localparam logic [3:0]  LAT_M1   = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

    localparam logic [1:0] OP_NOP    = 2'd0;
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_WRITE  = 2'd2;
    localparam logic [1:0] RESP_OK   = 2'd0;
    localparam logic [1:0] RESP_FAIL = 2'd2;

`ifdef DMI_RESPONDER_ADDR_CHECK_EN
    localparam logic [1:0] MISS_RESP = RESP_FAIL;
`else
    localparam logic [1:0] MISS_RESP = RESP_OK;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               hit_q, hit_d;
    logic [1:0]         resp_q, resp_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        bank_q [NUM_REGS];

    logic               req_fire;
    logic               req_hit;
    logic [IDX_W-1:0]   req_idx;
    logic               wr_en;

    // Address decode is done in 32 bits so that ADDR_BASE+NUM_REGS never
    // wraps inside the 7-bit address space.
    assign req_hit = ({25'd0, debug_req_bits_addr} >= 32'(ADDR_BASE)) &&
                     ({25'd0, debug_req_bits_addr} <  ADDR_END);
    assign req_idx = IDX_W'(debug_req_bits_addr - ADDR_BASE);

    // Ready is gated by reset_n so it stays low while reset is held, even
    // though the state register already reads IDLE.
    assign debug_req_ready      = (state_q == IDLE) && reset_n;
    assign req_fire             = debug_req_valid && debug_req_ready;
    assign debug_resp_valid     = (state_q == RESP);
    assign debug_resp_bits_resp = resp_q;
    assign debug_resp_bits_data = rdata_q;

    // Next-state logic. Response fields are only loaded on entry to RESP and
    // cleared on exit, so they hold steady for as long as the initiator
    // stalls. Reads capture the bank on the way into RESP, which is what
    // makes any earlier write visible to them.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        resp_d  = resp_q;
        rdata_d = rdata_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    resp_d  = RESP_OK;
                    rdata_d = 32'd0;
                    state_d = RESP;
                    case (debug_req_bits_op)
                        OP_READ: begin
                            idx_d = req_idx;
                            hit_d = req_hit;
                            if (RD_LATENCY == 0) begin
                                rdata_d = req_hit ? bank_q[req_idx] : 32'd0;
                                resp_d  = req_hit ? RESP_OK : MISS_RESP;
                            end else begin
                                state_d = WAIT;
                                cnt_d   = LAT_M1;
                            end
                        end
                        OP_WRITE: begin
                            if (req_hit) begin
                                wr_en = 1'b1;
                            end else begin
                                resp_d = MISS_RESP;
                            end
                        end
                        OP_NOP: begin
                            resp_d = RESP_OK;
                        end
                        default: begin
                            resp_d = RESP_FAIL;
                        end
                    endcase
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    rdata_d = hit_q ? bank_q[idx_q] : 32'd0;
                    resp_d  = hit_q ? RESP_OK : MISS_RESP;
                end else begin
                    cnt_d = 4'(cnt_q - 4'd1);
                end
            end
            RESP: begin
                if (debug_resp_ready) begin
                    state_d = IDLE;
                    resp_d  = RESP_OK;
                    rdata_d = 32'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            resp_q  <= RESP_OK;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hit_q   <= hit_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    // Register bank; writes land on the same edge that accepts the request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                bank_q[i] <= 32'd0;
            end
        end else if (wr_en) begin
            bank_q[req_idx] <= debug_req_bits_data;
        end
    end

    // Flatten the bank for external observation.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_q[32*g +: 32] = bank_q[g];
    end

endmodule

// File: tb/tb_dmi_responder.sv
// tb_dmi_responder
//
// Directed bench for dmi_responder at default parameters (16 registers at
// base 7'h04, read latency 2). Each task drives one scenario and compares
// outputs against hand-computed values.

module tb_dmi_responder;

    logic         clk;
    logic         reset_n;
    logic         debug_req_valid;
    logic         debug_req_ready;
    logic [6:0]   debug_req_bits_addr;
    logic [1:0]   debug_req_bits_op;
    logic [31:0]  debug_req_bits_data;
    logic         debug_resp_valid;
    logic         debug_resp_ready;
    logic [1:0]   debug_resp_bits_resp;
    logic [31:0]  debug_resp_bits_data;
    logic [511:0] regs_q;

    logic [511:0] expRegs;
    int           testsRun;
    int           testsFailed;

`ifdef DMI_RESPONDER_ADDR_CHECK_EN
    localparam logic [1:0] MISS_EXP = 2'd2;
`else
    localparam logic [1:0] MISS_EXP = 2'd0;
`endif

    dmi_responder dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .debug_req_valid      (debug_req_valid),
        .debug_req_ready      (debug_req_ready),
        .debug_req_bits_addr  (debug_req_bits_addr),
        .debug_req_bits_op    (debug_req_bits_op),
        .debug_req_bits_data  (debug_req_bits_data),
        .debug_resp_valid     (debug_resp_valid),
        .debug_resp_ready     (debug_resp_ready),
        .debug_resp_bits_resp (debug_resp_bits_resp),
        .debug_resp_bits_data (debug_resp_bits_data),
        .regs_q               (regs_q)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single accepting edge, then withdraw it.
    task automatic send(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        debug_req_valid     = 1'b1;
        debug_req_bits_op   = op;
        debug_req_bits_addr = addr;
        debug_req_bits_data = data;
        step();
        debug_req_valid     = 1'b0;
    endtask

    // Outputs while reset is held, then ready in the first cycle after release.
    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        testsRun++; if (debug_req_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ready got %b want 0", debug_req_ready); end
        testsRun++; if (debug_resp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_resp_valid got %b want 0", debug_resp_valid); end
        testsRun++; if (regs_q !== 512'd0) begin testsFailed++; $display("[TB] FAIL reset_regs got %h want 0", regs_q); end
        testsRun++; if ({debug_resp_bits_resp, debug_resp_bits_data} !== 34'd0) begin testsFailed++; $display("[TB] FAIL reset_resp_fields got %h/%h want 0/0", debug_resp_bits_resp, debug_resp_bits_data); end
        reset_n = 1'b1;
        #1;
        testsRun++; if (debug_req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL post_reset_ready got %b want 1", debug_req_ready); end
        expRegs = '0;
    endtask

    // Write hit to register 0 answers the very next cycle.
    task automatic test_write();
        send(2'd2, 7'h04, 32'hDEADBEEF);
        expRegs[31:0] = 32'hDEADBEEF;
        testsRun++; if (debug_resp_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL write_valid got %b want 1", debug_resp_valid); end
        testsRun++; if (debug_resp_bits_resp !== 2'd0 || debug_resp_bits_data !== 32'd0) begin testsFailed++; $display("[TB] FAIL write_resp got %h/%h want 0/0", debug_resp_bits_resp, debug_resp_bits_data); end
        testsRun++; if (regs_q !== expRegs) begin testsFailed++; $display("[TB] FAIL write_reg0 got %h want %h", regs_q[31:0], expRegs[31:0]); end
        step();
        testsRun++; if (debug_resp_valid !== 1'b0 || debug_req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL write_release got valid %b ready %b want 0 1", debug_resp_valid, debug_req_ready); end
    endtask

    // Read hit appears after two wait cycles, three cycles after acceptance.
    task automatic test_read_latency();
        send(2'd1, 7'h04, 32'd0);
        testsRun++; if (debug_resp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_cyc1 got %b want 0", debug_resp_valid); end
        step();
        testsRun++; if (debug_resp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_cyc2 got %b want 0", debug_resp_valid); end
        step();
        testsRun++; if (debug_resp_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL read_cyc3 got %b want 1", debug_resp_valid); end
        testsRun++; if (debug_resp_bits_data !== 32'hDEADBEEF || debug_resp_bits_resp !== 2'd0) begin testsFailed++; $display("[TB] FAIL read_data got %h/%h want 0/deadbeef", debug_resp_bits_resp, debug_resp_bits_data); end
        step();
    endtask

    // Address boundaries: last register hits, just-above and below base miss.
    task automatic test_address_boundary();
        send(2'd1, 7'h7F, 32'd0);
        step();
        step();
        testsRun++; if (debug_resp_valid !== 1'b1 || debug_resp_bits_resp !== MISS_EXP || debug_resp_bits_data !== 32'd0) begin testsFailed++; $display("[TB] FAIL read_miss got %b/%h/%h want 1/%h/0", debug_resp_valid, debug_resp_bits_resp, debug_resp_bits_data, MISS_EXP); end
        step();
        send(2'd2, 7'h13, 32'h12345678);
        expRegs[511:480] = 32'h12345678;
        testsRun++; if (regs_q !== expRegs || debug_resp_bits_resp !== 2'd0) begin testsFailed++; $display("[TB] FAIL write_last got %h resp %h want %h resp 0", regs_q[511:480], debug_resp_bits_resp, expRegs[511:480]); end
        step();
        send(2'd2, 7'h14, 32'hFFFFFFFF);
        testsRun++; if (regs_q !== expRegs || debug_resp_bits_resp !== MISS_EXP) begin testsFailed++; $display("[TB] FAIL write_above got resp %h want %h, bank changed %b", debug_resp_bits_resp, MISS_EXP, regs_q !== expRegs); end
        step();
        send(2'd2, 7'h03, 32'hFFFFFFFF);
        testsRun++; if (regs_q !== expRegs || debug_resp_bits_resp !== MISS_EXP) begin testsFailed++; $display("[TB] FAIL write_below got resp %h want %h, bank changed %b", debug_resp_bits_resp, MISS_EXP, regs_q !== expRegs); end
        step();
    endtask

    // Stalled response holds steady; a request pending meanwhile is only taken
    // the cycle after the response is released.
    task automatic test_back_to_back();
        debug_resp_ready = 1'b0;
        send(2'd1, 7'h04, 32'd0);
        step();
        step();
        debug_req_valid     = 1'b1;
        debug_req_bits_op   = 2'd2;
        debug_req_bits_addr = 7'h06;
        debug_req_bits_data = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            testsRun++; if (debug_resp_valid !== 1'b1 || debug_resp_bits_data !== 32'hDEADBEEF || debug_resp_bits_resp !== 2'd0 || debug_req_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_hold[%0d] got valid %b data %h resp %h ready %b want 1 deadbeef 0 0", i, debug_resp_valid, debug_resp_bits_data, debug_resp_bits_resp, debug_req_ready); end
            step();
        end
        debug_resp_ready = 1'b1;
        step();
        testsRun++; if (debug_resp_valid !== 1'b0 || debug_req_ready !== 1'b1 || regs_q !== expRegs) begin testsFailed++; $display("[TB] FAIL release_edge got valid %b ready %b reg2 %h want 0 1 0", debug_resp_valid, debug_req_ready, regs_q[95:64]); end
        step();
        debug_req_valid = 1'b0;
        expRegs[95:64] = 32'hCAFEF00D;
        testsRun++; if (debug_resp_valid !== 1'b1 || regs_q !== expRegs) begin testsFailed++; $display("[TB] FAIL queued_write got valid %b reg2 %h want 1 cafef00d", debug_resp_valid, regs_q[95:64]); end
        step();
    endtask

    // Reserved op fails without touching the bank; nop succeeds quietly.
    task automatic test_op_decode();
        send(2'd2, 7'h05, 32'hA5A5A5A5);
        expRegs[63:32] = 32'hA5A5A5A5;
        step();
        send(2'd3, 7'h05, 32'hFFFFFFFF);
        testsRun++; if (debug_resp_valid !== 1'b1 || debug_resp_bits_resp !== 2'd2 || debug_resp_bits_data !== 32'd0) begin testsFailed++; $display("[TB] FAIL op3_resp got %b/%h/%h want 1/2/0", debug_resp_valid, debug_resp_bits_resp, debug_resp_bits_data); end
        testsRun++; if (regs_q !== expRegs) begin testsFailed++; $display("[TB] FAIL op3_bank got reg1 %h want %h", regs_q[63:32], expRegs[63:32]); end
        step();
        send(2'd0, 7'h04, 32'h11111111);
        testsRun++; if (debug_resp_valid !== 1'b1 || debug_resp_bits_resp !== 2'd0 || regs_q !== expRegs) begin testsFailed++; $display("[TB] FAIL nop got valid %b resp %h reg0 %h want 1 0 deadbeef", debug_resp_valid, debug_resp_bits_resp, regs_q[31:0]); end
        step();
    endtask

    // Reset during a read wait abandons it: no response ever appears.
    task automatic test_reset_in_wait();
        send(2'd1, 7'h05, 32'd0);
        reset_n = 1'b0;
        #1;
        expRegs = '0;
        testsRun++; if (regs_q !== expRegs || debug_req_ready !== 1'b0 || debug_resp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL wait_reset got regs0 %b ready %b valid %b want 1 0 0", regs_q === 512'd0, debug_req_ready, debug_resp_valid); end
        step();
        reset_n = 1'b1;
        #1;
        testsRun++; if (debug_req_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL wait_reset_ready got %b want 1", debug_req_ready); end
        for (int i = 0; i < 5; i++) begin
            step();
            testsRun++; if (debug_resp_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL ghost_resp[%0d] got %b want 0", i, debug_resp_valid); end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        testsRun            = 0;
        testsFailed         = 0;
        expRegs             = '0;
        reset_n             = 1'b0;
        debug_req_valid     = 1'b0;
        debug_req_bits_addr = 7'd0;
        debug_req_bits_op   = 2'd0;
        debug_req_bits_data = 32'd0;
        debug_resp_ready    = 1'b1;
        test_reset();
        test_write();
        test_read_latency();
        test_address_boundary();
        test_back_to_back();
        test_op_decode();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
